// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//
// Boot-time writer for the instruction memory. A byte stream arriving over a
// valid/ready handshake carries a 32-bit big-endian word count N followed by
// N big-endian instruction words. Each assembled word is written to the
// instruction memory at BASE_ADDR + 4*index. The CPU core is held stalled
// (cpu_hold=1) until a complete image has been written successfully.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   single-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_valid  in   a byte is offered on in_data
//   in_data   in   offered byte
//   in_ready  out  loader accepts a byte this cycle
//   we        out  instruction memory write enable (one-cycle pulse per word)
//   waddr     out  word-aligned byte address of the word being written
//   wdata     out  instruction word being written
//   busy      out  load in progress (header or data phase)
//   done      out  last load completed successfully (level)
//   err       out  last load aborted (level)
//   cpu_hold  out  stalls the core's PC and fetch while high
// ---------------------------------------------------------------------------
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 131071,
    parameter int          IDX_W     = 17,
    parameter int          TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    localparam int                TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam logic [31:0]       MAX_N     = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_nxt;
    logic [1:0]         byte_cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [31:0]        count_q;
    logic [23:0]        shift_q;
    // Set when the final word's write has been issued; the DATA state lingers
    // for that one cycle (not accepting bytes) so done rises after the pulse.
    logic               fin_q;

    logic               active;
    logic               xfer;
    logic               last_lane;
    logic [31:0]        hdr_word;
    logic [31:0]        data_word;
    logic [31:0]        idx_ext;
    logic [TMO_W-1:0]   tmo_inc;
    logic               tmo_hit;

    // Decoded status, all from registered state
    assign active   = (state_q == S_HDR) || (state_q == S_DATA);
    assign busy     = active;
    assign in_ready = active && !fin_q;
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign cpu_hold = (state_q != S_DONE);

    assign xfer      = in_valid && in_ready;
    assign last_lane = (byte_cnt_q == 2'd3);
    assign hdr_word  = {count_q[23:0], in_data};
    assign data_word = {shift_q, in_data};
    assign idx_ext   = 32'(idx_q);
    assign tmo_inc   = tmo_q + 1'b1;
    assign tmo_hit   = !xfer && (tmo_inc == TMO_LIMIT);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_HDR;
            end
            S_HDR: begin
                if (xfer && last_lane) begin
                    if (hdr_word == 32'd0)      state_nxt = S_DONE;
                    else if (hdr_word > MAX_N)  state_nxt = S_ERR;
                    else                        state_nxt = S_DATA;
                end else if (tmo_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                if (fin_q)        state_nxt = S_DONE;
                else if (tmo_hit) state_nxt = S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            idx_q      <= '0;
            tmo_q      <= '0;
            count_q    <= 32'd0;
            shift_q    <= 24'd0;
            fin_q      <= 1'b0;
            we         <= 1'b0;
            waddr      <= BASE_ADDR;
            wdata      <= 32'd0;
        end else begin
            state_q <= state_nxt;
            we      <= 1'b0;
            if (!active) begin
                if (start) begin
                    byte_cnt_q <= 2'd0;
                    idx_q      <= '0;
                    tmo_q      <= '0;
                    fin_q      <= 1'b0;
                end
            end else if (xfer) begin
                tmo_q      <= '0;
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (state_q == S_HDR) begin
                    count_q <= hdr_word;
                end else if (last_lane) begin
                    // Registered write: visible the cycle after the 4th byte
                    we    <= 1'b1;
                    waddr <= BASE_ADDR + (idx_ext << 2);
                    wdata <= data_word;
                    idx_q <= idx_q + 1'b1;
                    if (idx_ext == count_q - 32'd1) fin_q <= 1'b1;
                end else begin
                    shift_q <= {shift_q[15:0], in_data};
                end
            end else begin
                tmo_q <= tmo_inc;
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_loader: directed self-checking bench for inst_loader.
// ---------------------------------------------------------------------------
module tb_inst_loader;

    localparam int TIMEOUT = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cyc  [64];
    int          wr_n = 0;

    inst_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(131071),
        .IDX_W    (17),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Log every write pulse seen on the memory port
    always @(negedge clk) begin
        if (we === 1'b1 && wr_n < 64) begin
            wr_addr[wr_n] = waddr;
            wr_data[wr_n] = wdata;
            wr_cyc[wr_n]  = cyc;
            wr_n++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_ready: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            repeat (gap) @(negedge clk);
            send_byte(w[31-8*i -: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, we, busy, done, err, cpu_hold} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/we/busy/done/err/hold=%b required 000001",
                     {in_ready, we, busy, done, err, cpu_hold});
        end
        checks++;
        if (waddr !== 32'h0 || wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: waddr=%h wdata=%h required 0 0", waddr, wdata);
        end
    endtask

    task automatic run_two_word(input int gap, input string tag);
        int base;
        base = wr_n;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: busy=%b in_ready=%b done=%b required 1 1 0",
                     tag, busy, in_ready, done);
        end
        send_word(32'h0000_0002, gap);
        send_word(32'h3401_0010, gap);
        send_word(32'h0000_0000, gap);
        checks++;
        if (we !== 1'b1 || waddr !== 32'h4 || wdata !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_last_we: we=%b waddr=%h wdata=%h done=%b required 1 4 0 0",
                     tag, we, waddr, wdata, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || we !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b hold=%b busy=%b we=%b err=%b required 1 0 0 0 0",
                     tag, done, cpu_hold, busy, we, err);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_n - base !== 2) begin
            errors++;
            $display("FAIL %s_count: writes=%0d required 2", tag, wr_n - base);
        end else begin
            checks++;
            if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h3401_0010) begin
                errors++;
                $display("FAIL %s_w0: addr=%h data=%h required 0 34010010",
                         tag, wr_addr[base], wr_data[base]);
            end
            checks++;
            if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h0) begin
                errors++;
                $display("FAIL %s_w1: addr=%h data=%h required 4 0",
                         tag, wr_addr[base+1], wr_data[base+1]);
            end
            if (gap == 0) begin
                checks++;
                if (wr_cyc[base+1] - wr_cyc[base] !== 4) begin
                    errors++;
                    $display("FAIL %s_rate: spacing=%0d required 4",
                             tag, wr_cyc[base+1] - wr_cyc[base]);
                end
            end
        end
    endtask

    task automatic test_nominal();
        run_two_word(0, "nominal");
    endtask

    task automatic test_throttled();
        run_two_word(3, "throttled");
    endtask

    task automatic test_empty_oversize();
        int base;
        base = wr_n;
        pulse_start();
        send_word(32'h0000_0000, 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: done=%b busy=%b in_ready=%b hold=%b required 1 0 0 0",
                     done, busy, in_ready, cpu_hold);
        end
        pulse_start();
        checks++;
        if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: done=%b hold=%b busy=%b required 0 1 1",
                     done, cpu_hold, busy);
        end
        send_word(32'h0002_0000, 0);
        checks++;
        if (err !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL oversize_err: err=%b hold=%b busy=%b done=%b required 1 1 0 0",
                     err, cpu_hold, busy, done);
        end
        // Bytes offered in ERR must not be accepted
        in_valid = 1'b1; in_data = 8'hEE;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL oversize_hold: in_ready=%b hold=%b err=%b required 0 1 1",
                     in_ready, cpu_hold, err);
        end
        in_valid = 1'b0;
        checks++;
        if (wr_n - base !== 0) begin
            errors++;
            $display("FAIL empty_oversize_nowe: writes=%0d required 0", wr_n - base);
        end
    endtask

    task automatic test_timeout();
        int base;
        base = wr_n;
        pulse_start();
        send_word(32'h0000_0001, 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TIMEOUT - 5) @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%b busy=%b required 0 1", err, busy);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b1 || wr_n - base !== 0) begin
            errors++;
            $display("FAIL timeout_err: err=%b busy=%b hold=%b writes=%0d required 1 0 1 0",
                     err, busy, cpu_hold, wr_n - base);
        end
        base = wr_n;
        pulse_start();
        send_word(32'h0000_0001, 0);
        send_word(32'hDEAD_BEEF, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || wr_n - base !== 1) begin
            errors++;
            $display("FAIL timeout_reload: done=%b err=%b writes=%0d required 1 0 1",
                     done, err, wr_n - base);
        end else begin
            checks++;
            if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL timeout_reload_w: addr=%h data=%h required 0 deadbeef",
                         wr_addr[base], wr_data[base]);
            end
        end
    endtask

    task automatic test_async_reset();
        int base;
        base = wr_n;
        pulse_start();
        send_word(32'h0000_0003, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, we, busy, done, err, cpu_hold} !== 6'b000001 ||
            waddr !== 32'h0 || wdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: ctrl=%b waddr=%h wdata=%h required 000001 0 0",
                     {in_ready, we, busy, done, err, cpu_hold}, waddr, wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h33;
        repeat (4) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || wr_n - base !== 0) begin
            errors++;
            $display("FAIL reset_no_resume: in_ready=%b busy=%b writes=%0d required 0 0 0",
                     in_ready, busy, wr_n - base);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_start_abuse();
        int base;
        base = wr_n;
        pulse_start();
        send_word(32'h0000_0002, 0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL abuse_busy: busy=%b done=%b required 1 0", busy, done);
        end
        send_byte(8'hA3);
        send_byte(8'hA4);
        send_word(32'h55AA_0FF0, 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || wr_n - base !== 2) begin
            errors++;
            $display("FAIL abuse_done: done=%b writes=%0d required 1 2", done, wr_n - base);
        end else begin
            checks++;
            if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hA1A2_A3A4 ||
                wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h55AA_0FF0) begin
                errors++;
                $display("FAIL abuse_writes: %h/%h %h/%h required 0/a1a2a3a4 4/55aa0ff0",
                         wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_throttled();
        test_empty_oversize();
        test_timeout();
        test_async_reset();
        test_start_abuse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
